// File: rtl/wbapb_master.sv
// Pipelined-Wishbone slave to APB4 master bridge, one transfer outstanding at a time.
// Latency: ack/err three cycles after accept, plus one cycle per PREADY-low ACCESS cycle.
// Backpressure: o_wb_stall is high whenever a transfer is in flight or reset is asserted.
module wbapb_master #(
  parameter int         AW       = 12,
  parameter int         DW       = 32,
  parameter logic [2:0] OPT_PROT = 3'b000,
  localparam int        APBLSB   = $clog2(DW) - 3
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-APBLSB-1:0] i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [DW-1:0]        o_wb_data,
  output logic                 o_wb_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic                 PREADY,
  output logic [AW-1:0]        PADDR,
  output logic                 PWRITE,
  output logic [DW-1:0]        PWDATA,
  output logic [DW/8-1:0]      PWSTRB,
  output logic [2:0]           PPROT,
  input  logic [DW-1:0]        PRDATA,
  input  logic                 PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   aborted;

  assign o_wb_stall = !PRESETn || (state != IDLE);
  assign PPROT      = OPT_PROT;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      aborted   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWSTRB    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= {i_wb_addr, {APBLSB{1'b0}}};
            PWRITE  <= i_wb_we;
            PWDATA  <= i_wb_data;
            PWSTRB  <= i_wb_we ? i_wb_sel : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          if (!i_wb_cyc)
            aborted <= 1'b1;
        end
        ACCESS: begin
          if (!i_wb_cyc)
            aborted <= 1'b1;
          // APB cannot be cancelled, so an abandoned request still finishes here silently.
          if (PREADY) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            aborted <= 1'b0;
            if (!PWRITE)
              o_wb_data <= PRDATA;
            if (!aborted && i_wb_cyc) begin
              o_wb_ack <= !PSLVERR;
              o_wb_err <= PSLVERR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbapb_master.sv
// Directed bench for wbapb_master with a behavioural APB memory that has programmable wait states and error.
module tb_wbapb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [9:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0] o_wb_data;
  logic        PSEL, PENABLE, PREADY, PWRITE, PSLVERR;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PWSTRB;
  logic [2:0]  PPROT;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];
  int          wcnt;
  int          wait_n;
  logic        slverr_en;

  always #5 PCLK = ~PCLK;

  wbapb_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data), .o_wb_err(o_wb_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PWSTRB(PWSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Completer: ready after wait_n ACCESS cycles, byte-strobed writes on completion.
  assign PREADY  = PSEL && PENABLE && (wcnt == wait_n);
  assign PRDATA  = mem[PADDR[11:2]];
  assign PSLVERR = slverr_en;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE)
      for (int b = 0; b < 4; b++)
        if (PWSTRB[b]) mem[PADDR[11:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int lat, input logic eerr);
    int   n;
    logic done;
    @(negedge PCLK);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
    chk("stall_idle", 32'(o_wb_stall), 32'd0);
    @(posedge PCLK);
    #1 i_wb_stb = 1'b0;
    done = 1'b0;
    n    = 0;
    while (!done && n < 20) begin
      @(negedge PCLK);
      n++;
      if (o_wb_ack || o_wb_err) done = 1'b1;
      else begin
        chk("stall_busy", 32'(o_wb_stall), 32'd1);
        chk("psel",       32'(PSEL),       32'd1);
        chk("penable",    32'(PENABLE),    32'(n > 1));
        chk("paddr",      32'(PADDR),      32'({a, 2'b00}));
        chk("pwrite",     32'(PWRITE),     32'(we));
        chk("pwdata",     PWDATA,          d);
        chk("pwstrb",     32'(PWSTRB),     32'(we ? s : 4'h0));
        chk("pprot",      32'(PPROT),      32'd0);
      end
    end
    chk("done",     32'(done),     32'd1);
    chk("latency",  32'(n),        32'(lat));
    chk("ack",      32'(o_wb_ack), 32'(!eerr));
    chk("err",      32'(o_wb_err), 32'(eerr));
    chk("psel_end", 32'(PSEL),     32'd0);
    i_wb_cyc = 1'b0;
    @(negedge PCLK);
    chk("ack_pulse", 32'(o_wb_ack), 32'd0);
    chk("err_pulse", 32'(o_wb_err), 32'd0);
  endtask

  initial begin
    logic saw_en, any_resp;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    PRESETn = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
    wait_n = 0; slverr_en = 1'b0;

    #12;
    chk("rst_psel",  32'(PSEL),       32'd0);
    chk("rst_pen",   32'(PENABLE),    32'd0);
    chk("rst_ack",   32'(o_wb_ack),   32'd0);
    chk("rst_err",   32'(o_wb_err),   32'd0);
    chk("rst_stall", 32'(o_wb_stall), 32'd1);
    chk("rst_paddr", 32'(PADDR),      32'd0);
    chk("rst_rdata", o_wb_data,       32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("stall_after_rst", 32'(o_wb_stall), 32'd0);

    // Full write then read back
    xfer(1'b1, 10'd5, 32'h12345678, 4'hF, 3, 1'b0);
    xfer(1'b0, 10'd5, 32'h0, 4'h0, 3, 1'b0);
    chk("rd_full", o_wb_data, 32'h12345678);

    // Partial strobe; a write leaves o_wb_data untouched
    xfer(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101, 3, 1'b0);
    chk("rdata_hold", o_wb_data, 32'h12345678);
    xfer(1'b0, 10'd5, 32'h0, 4'h0, 3, 1'b0);
    chk("rd_partial", o_wb_data, 32'h12BB56DD);

    // Four wait states
    wait_n = 4;
    xfer(1'b1, 10'd7, 32'hCAFEF00D, 4'hF, 7, 1'b0);
    wait_n = 0;

    // Slave error, then a normal transfer
    slverr_en = 1'b1;
    xfer(1'b0, 10'd5, 32'h0, 4'h0, 3, 1'b1);
    slverr_en = 1'b0;
    xfer(1'b0, 10'd7, 32'h0, 4'h0, 3, 1'b0);
    chk("rd_after_err", o_wb_data, 32'hCAFEF00D);

    // Abort in SETUP: APB still completes, no Wishbone response
    @(negedge PCLK);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = 10'd9; i_wb_data = 32'hDEADBEEF; i_wb_sel = 4'hF;
    @(posedge PCLK);
    #1 i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    saw_en = 1'b0; any_resp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      if (PENABLE) saw_en = 1'b1;
      if (o_wb_ack || o_wb_err) any_resp = 1'b1;
    end
    chk("abort_penable", 32'(saw_en),     32'd1);
    chk("abort_noresp",  32'(any_resp),   32'd0);
    chk("abort_psel",    32'(PSEL),       32'd0);
    chk("abort_stall",   32'(o_wb_stall), 32'd0);
    xfer(1'b0, 10'd9, 32'h0, 4'h0, 3, 1'b0);
    chk("rd_after_abort", o_wb_data, 32'hDEADBEEF);

    // Asynchronous reset in the middle of ACCESS
    wait_n = 3;
    @(negedge PCLK);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
    i_wb_addr = 10'd5; i_wb_data = 32'h0; i_wb_sel = 4'h0;
    @(posedge PCLK);
    #1 i_wb_stb = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_pen", 32'(PENABLE), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_psel",  32'(PSEL),       32'd0);
    chk("arst_pen",   32'(PENABLE),    32'd0);
    chk("arst_ack",   32'(o_wb_ack),   32'd0);
    chk("arst_err",   32'(o_wb_err),   32'd0);
    chk("arst_stall", 32'(o_wb_stall), 32'd1);
    chk("arst_rdata", o_wb_data,       32'd0);
    i_wb_cyc = 1'b0;
    wait_n = 0;
    @(posedge PCLK);
    #1 chk("arst_stall_hold", 32'(o_wb_stall), 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("no_ack_after_rst", 32'(o_wb_ack), 32'd0);
    xfer(1'b0, 10'd0, 32'h0, 4'h0, 3, 1'b0);
    chk("rd_word0", o_wb_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
